div_seq_ctrl: RTL

- Sequential controller for the ALU's 16-bit unsigned non-restoring divider.
- One shared add/subtract stage iterates over 16 cycles plus one correction cycle, replacing the 16-stage combinational array when area matters.
- Exposes a start/busy/done handshake to the ALU issue logic.
- Handles divide-by-zero in a single cycle without iterating.

---
 rtl/div_seq_ctrl_if.sv | 25 ++
 rtl/div_seq_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/div_seq_ctrl_if.sv
// Handshake/operand bundle between the ALU issue logic and div_seq_ctrl.
//   master : issue side  -- drives start/dividend/divisor, observes results
//   slave  : divider side -- samples the request, drives busy/done/results
interface div_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequential unsigned non-restoring divider controller.
// A single shared add/sub stage runs WIDTH iterations plus one remainder
// correction edge. A zero divisor completes on the accept edge.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - div_seq_ctrl_if.slave: start/dividend/divisor in,
//           busy/done/quotient/remainder/div_by_zero out (all registered)
module div_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst_n,
  div_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;       // signed partial remainder
  logic [WIDTH-1:0] q_q, q_d;       // dividend in / quotient bits out
  logic [WIDTH-1:0] d_q, d_d;       // latched divisor
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  // One non-restoring step: shift in the next dividend bit, then subtract
  // when the partial remainder is non-negative, add back when negative.
  logic [WIDTH:0] s, a_step;
  assign s      = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign a_step = a_q[WIDTH] ? (s + {1'b0, d_q}) : (s - {1'b0, d_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;   // done is a single-cycle pulse
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            // Short-circuit: no iteration, result visible next cycle.
            quo_d  = '1;
            rem_d  = bus.dividend;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            a_d     = '0;
            q_d     = bus.dividend;
            d_d     = bus.divisor;
            cnt_d   = CW'(WIDTH);
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        a_d   = a_step;
        q_d   = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        // A negative final remainder is restored by one add of the divisor.
        rem_d   = a_q[WIDTH] ? (a_q[WIDTH-1:0] + d_q) : a_q[WIDTH-1:0];
        quo_d   = q_q;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule
